// File: rtl/seq_divider_8bit_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_8bit_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Controller <-> divider handshake and operand/result bus.
interface seq_divider_8bit_if
  import seq_divider_8bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8bit_cla_subtractor.sv
// Trial subtractor a - b computed as a + ~b + 1 with lookahead carries.
module cla_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic [N-1:0] bn, g, p;
  logic [N:0]   c;
  logic         run, acc;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  // Each carry is the OR of every generate propagated up to it, plus the
  // carry-in (tied to 1) propagated through all lower bits.
  always_comb begin
    c    = '0;
    run  = 1'b1;
    acc  = 1'b0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      run = 1'b1;
      acc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (g[j] & run);
        run = run & p[j];
      end
      c[i+1] = acc | run;
    end
  end

  assign diff   = p ^ c[N-1:0];
  // No carry out of a + ~b + 1 means a < b.
  assign borrow = ~c[N];
endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
module seq_divider_8bit
  import seq_divider_8bit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_divider_8bit_if.slave  bus
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;       // latched divisor
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder (always < divisor, so top bit never needed)
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             diff_sign_unused;

  assign trial = {r_q, q_q[WIDTH-1]};

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, d_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Sign bit of diff duplicates borrow; only the low bits are stored.
  assign diff_sign_unused = diff[WIDTH];

  // Next-state, datapath and result-register updates.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          q_d   = bus.dividend;
          d_d   = bus.divisor;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Restore on borrow, otherwise keep the difference; T < 2D so it fits.
        r_d   = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule
